// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: windowed FFT peak detector with pipelined magnitude; define SECOND_PEAK_EN for runner-up outputs
module fft_peak_tracker #(
  parameter int FFT_SIZE = 2048,
  parameter int DATA_WIDTH = 22,
  parameter int SAMPLE_RATE = 1000000,
  parameter int IDX_W = $clog2(FFT_SIZE)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic s_valid,
  input  logic s_sync,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  input  logic [IDX_W-1:0] bin_lo,
  input  logic [IDX_W-1:0] bin_hi,
  input  logic [2*DATA_WIDTH-1:0] threshold,
  output logic peak_valid,
  output logic peak_found,
  output logic [IDX_W-1:0] peak_index,
  output logic [2*DATA_WIDTH-1:0] peak_mag,
  output logic [31:0] peak_frequency,
  output logic [15:0] frame_count,
  output logic [7:0] sync_err_count
`ifdef SECOND_PEAK_EN
  ,
  output logic [IDX_W-1:0] peak2_index,
  output logic [2*DATA_WIDTH-1:0] peak2_mag
`endif
);
  localparam int MW = 2*DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FFT_SIZE-1);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] cnt, lo_l, hi_l, lo_rep, idx, lo_c, hi_c, idx_out;
  logic [MW-1:0] thr_l, thr_rep;
  logic ne_rep, start, abort, acc, last, cand;
  logic signed [DATA_WIDTH-1:0] re, im;
  logic [MW-1:0] re_sq, im_sq;
  logic p1_v, p1_f, p1_l, p1_c;
  logic [IDX_W-1:0] p1_i;
  logic [MW-1:0] p1_re, p1_im;
  logic p2_v, p2_f, p2_l, p2_c;
  logic [IDX_W-1:0] p2_i;
  logic [MW-1:0] p2_mag;
  logic l3, first, upd, gt1;
  logic [MW-1:0] m1, m1_b, m1_n;
  logic [IDX_W-1:0] i1, i1_b, i1_n;
`ifdef SECOND_PEAK_EN
  logic two_rep, gt2;
  logic [MW-1:0] m2, m2_b, m2_n;
  logic [IDX_W-1:0] i2, i2_b, i2_n;
`endif
  always_comb begin
    start = s_valid && s_sync;
    abort = start && state == ACCUM;
    acc = s_valid && (s_sync || state == ACCUM);
    last = acc && !s_sync && cnt == LAST;
    idx = s_sync ? '0 : cnt;
    lo_c = s_sync ? bin_lo : lo_l;
    hi_c = s_sync ? bin_hi : hi_l;
    cand = lo_c <= idx && idx <= hi_c;
    re = s_data[MW-1:DATA_WIDTH];
    im = s_data[DATA_WIDTH-1:0];
    re_sq = MW'(re) * MW'(re);
    im_sq = MW'(im) * MW'(im);
    first = p2_v && p2_f;
    m1_b = first ? '0 : m1;
    i1_b = first ? '0 : i1;
    upd = p2_v && p2_c;
    gt1 = upd && p2_mag > m1_b;
    m1_n = gt1 ? p2_mag : m1_b;
    i1_n = gt1 ? p2_i : i1_b;
`ifdef SECOND_PEAK_EN
    m2_b = first ? '0 : m2;
    i2_b = first ? '0 : i2;
    gt2 = upd && p2_mag > m2_b;
    m2_n = gt1 ? m1_b : gt2 ? p2_mag : m2_b;
    i2_n = gt1 ? i1_b : gt2 ? p2_i : i2_b;
`endif
    idx_out = !ne_rep ? '0 : m1 == '0 ? lo_rep : i1;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? ACCUM : IDLE;
      ACCUM: state_nxt = last ? DRAIN : ACCUM;
      DRAIN: state_nxt = start ? ACCUM : l3 ? REPORT : DRAIN;
      REPORT: state_nxt = start ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      lo_l <= '0;
      hi_l <= '0;
      thr_l <= '0;
      lo_rep <= '0;
      thr_rep <= '0;
      ne_rep <= 1'b0;
      {p1_v, p1_f, p1_l, p1_c, p1_i, p1_re, p1_im} <= '0;
      {p2_v, p2_f, p2_l, p2_c, p2_i, p2_mag} <= '0;
      l3 <= 1'b0;
      m1 <= '0;
      i1 <= '0;
      peak_valid <= 1'b0;
      peak_found <= 1'b0;
      peak_index <= '0;
      peak_mag <= '0;
      peak_frequency <= '0;
      frame_count <= '0;
      sync_err_count <= '0;
`ifdef SECOND_PEAK_EN
      two_rep <= 1'b0;
      m2 <= '0;
      i2 <= '0;
      peak2_index <= '0;
      peak2_mag <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (acc) cnt <= idx + 1'b1;
      if (start) begin
        lo_l <= bin_lo;
        hi_l <= bin_hi;
        thr_l <= threshold;
      end
      if (last) begin
        lo_rep <= lo_l;
        thr_rep <= thr_l;
        ne_rep <= lo_l <= hi_l;
`ifdef SECOND_PEAK_EN
        two_rep <= lo_l < hi_l;
`endif
      end
      {p1_v, p1_f, p1_l, p1_c, p1_i, p1_re, p1_im} <= {acc, s_sync, last, cand, idx, re_sq, im_sq};
      {p2_v, p2_f, p2_l, p2_c, p2_i} <= {p1_v && !abort, p1_f, p1_l, p1_c, p1_i};
      p2_mag <= p1_re + p1_im;
      m1 <= m1_n;
      i1 <= i1_n;
`ifdef SECOND_PEAK_EN
      m2 <= m2_n;
      i2 <= i2_n;
`endif
      l3 <= p2_v && p2_l;
      peak_valid <= l3;
      if (l3) begin
        peak_found <= ne_rep && m1 > thr_rep;
        peak_index <= idx_out;
        peak_mag <= ne_rep ? m1 : '0;
        peak_frequency <= 32'((64'(idx_out) * 64'(SAMPLE_RATE)) >> IDX_W);
        frame_count <= frame_count + 1'b1;
`ifdef SECOND_PEAK_EN
        peak2_index <= two_rep ? i2 : '0;
        peak2_mag <= two_rep ? m2 : '0;
`endif
      end
      if (abort && sync_err_count != 8'hFF) sync_err_count <= sync_err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_peak_tracker.sv
// tb_fft_peak_tracker: directed-vector bench for fft_peak_tracker at FFT_SIZE=16, DATA_WIDTH=22
module tb_fft_peak_tracker;
  localparam int N = 16;
  localparam int DW = 22;
  localparam int IW = 4;
  localparam int MW = 44;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic s_valid = 1'b0;
  logic s_sync = 1'b0;
  logic [MW-1:0] s_data = '0;
  logic [IW-1:0] bin_lo = '0;
  logic [IW-1:0] bin_hi = '0;
  logic [MW-1:0] threshold = '0;
  logic peak_valid, peak_found;
  logic [IW-1:0] peak_index;
  logic [MW-1:0] peak_mag;
  logic [31:0] peak_frequency;
  logic [15:0] frame_count;
  logic [7:0] sync_err_count;
`ifdef SECOND_PEAK_EN
  logic [IW-1:0] peak2_index;
  logic [MW-1:0] peak2_mag;
`endif
  int vectors = 0;
  int errors = 0;
  logic signed [DW-1:0] fre [N];
  logic signed [DW-1:0] fim [N];
  logic [IW-1:0] q_idx [$];
  logic [MW-1:0] q_mag [$];
  logic [31:0] q_freq [$];
  logic [15:0] fc0;
  logic [7:0] se0;

  fft_peak_tracker #(.FFT_SIZE(N), .DATA_WIDTH(DW), .SAMPLE_RATE(1000000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .s_valid(s_valid), .s_sync(s_sync), .s_data(s_data),
    .bin_lo(bin_lo), .bin_hi(bin_hi), .threshold(threshold),
    .peak_valid(peak_valid), .peak_found(peak_found), .peak_index(peak_index), .peak_mag(peak_mag),
    .peak_frequency(peak_frequency), .frame_count(frame_count), .sync_err_count(sync_err_count)
`ifdef SECOND_PEAK_EN
    , .peak2_index(peak2_index), .peak2_mag(peak2_mag)
`endif
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (peak_valid) begin
      q_idx.push_back(peak_index);
      q_mag.push_back(peak_mag);
      q_freq.push_back(peak_frequency);
    end
  end

  task automatic drive(input logic v, input logic sy, input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    s_valid = v;
    s_sync = sy;
    s_data = {re, im};
    @(posedge clk_in);
    #1;
    s_valid = 1'b0;
    s_sync = 1'b0;
  endtask

  task automatic fill(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    for (int b = 0; b < N; b++) begin
      fre[b] = re;
      fim[b] = im;
    end
  endtask

  task automatic load_basic();
    fill(22'sd1, 22'sd1);
    fre[5] = 22'sd30;
    fim[5] = 22'sd40;
  endtask

  task automatic clear_q();
    q_idx.delete();
    q_mag.delete();
    q_freq.delete();
  endtask

  task automatic run_frame(input logic [IW-1:0] lo, input logic [IW-1:0] hi, input logic [MW-1:0] thr, input bit gaps, input int nb);
    bin_lo = lo;
    bin_hi = hi;
    threshold = thr;
    for (int b = 0; b < nb; b++) begin
      if (gaps) repeat ($urandom_range(2, 0)) drive('0, '0, '0, '0);
      drive(1'b1, b == 0, fre[b], fim[b]);
    end
  endtask

  task automatic wait_reports(input int n);
    for (int i = 0; i < 40 && q_idx.size() < n; i++) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    #1;
    vectors++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", peak_valid); end
    vectors++; if (peak_found !== 1'b0) begin errors++; $display("FAIL reset_found got %0d exp 0", peak_found); end
    vectors++; if (peak_index !== '0) begin errors++; $display("FAIL reset_index got %0d exp 0", peak_index); end
    vectors++; if (peak_mag !== '0) begin errors++; $display("FAIL reset_mag got %0d exp 0", peak_mag); end
    vectors++; if (peak_frequency !== '0) begin errors++; $display("FAIL reset_freq got %0d exp 0", peak_frequency); end
    vectors++; if (frame_count !== '0) begin errors++; $display("FAIL reset_frames got %0d exp 0", frame_count); end
    vectors++; if (sync_err_count !== '0) begin errors++; $display("FAIL reset_syncerr got %0d exp 0", sync_err_count); end
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic test_basic();
    load_basic();
    run_frame(4'd2, 4'd10, 44'd100, 1'b0, N);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_in);
      #1;
      vectors++; if (peak_valid !== (k == 3)) begin errors++; $display("FAIL latency_edge%0d got %0d exp %0d", k, peak_valid, k == 3); end
    end
    vectors++; if (peak_index !== 4'd5) begin errors++; $display("FAIL basic_index got %0d exp 5", peak_index); end
    vectors++; if (peak_mag !== 44'd2500) begin errors++; $display("FAIL basic_mag got %0d exp 2500", peak_mag); end
    vectors++; if (peak_found !== 1'b1) begin errors++; $display("FAIL basic_found got %0d exp 1", peak_found); end
    vectors++; if (peak_frequency !== 32'd312500) begin errors++; $display("FAIL basic_freq got %0d exp 312500", peak_frequency); end
    vectors++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frames got %0d exp 1", frame_count); end
  endtask

  task automatic test_threshold_equal();
    clear_q();
    load_basic();
    run_frame(4'd2, 4'd10, 44'd2500, 1'b0, N);
    wait_reports(1);
    vectors++; if (peak_found !== 1'b0) begin errors++; $display("FAIL thr_eq_found got %0d exp 0", peak_found); end
    vectors++; if (peak_index !== 4'd5) begin errors++; $display("FAIL thr_eq_index got %0d exp 5", peak_index); end
    vectors++; if (peak_mag !== 44'd2500) begin errors++; $display("FAIL thr_eq_mag got %0d exp 2500", peak_mag); end
  endtask

  task automatic test_overflow();
    clear_q();
    fill(22'sd1, 22'sd1);
    fre[3] = 22'h200000;
    fim[3] = 22'h200000;
    fre[7] = 22'h200000;
    fim[7] = 22'h200000;
    run_frame(4'd0, 4'd15, 44'd100, 1'b0, N);
    wait_reports(1);
    vectors++; if (peak_index !== 4'd3) begin errors++; $display("FAIL ovf_tie_index got %0d exp 3", peak_index); end
    vectors++; if (peak_mag !== 44'h800_0000_0000) begin errors++; $display("FAIL ovf_mag got %0h exp 80000000000", peak_mag); end
    vectors++; if (peak_found !== 1'b1) begin errors++; $display("FAIL ovf_found got %0d exp 1", peak_found); end
    vectors++; if (peak_frequency !== 32'd187500) begin errors++; $display("FAIL ovf_freq got %0d exp 187500", peak_frequency); end
  endtask

  task automatic test_empty_window();
    clear_q();
    fc0 = frame_count;
    load_basic();
    run_frame(4'd12, 4'd4, 44'd100, 1'b0, N);
    wait_reports(1);
    vectors++; if (q_idx.size() != 1) begin errors++; $display("FAIL empty_reports got %0d exp 1", q_idx.size()); end
    vectors++; if (peak_found !== 1'b0) begin errors++; $display("FAIL empty_found got %0d exp 0", peak_found); end
    vectors++; if (peak_index !== 4'd0) begin errors++; $display("FAIL empty_index got %0d exp 0", peak_index); end
    vectors++; if (peak_mag !== 44'd0) begin errors++; $display("FAIL empty_mag got %0d exp 0", peak_mag); end
    vectors++; if (frame_count !== fc0 + 16'd1) begin errors++; $display("FAIL empty_frames got %0d exp %0d", frame_count, fc0 + 16'd1); end
  endtask

  task automatic test_zero_window();
    clear_q();
    fill(22'sd0, 22'sd0);
    fre[2] = 22'sd9;
    run_frame(4'd6, 4'd9, 44'd0, 1'b0, N);
    wait_reports(1);
    vectors++; if (peak_index !== 4'd6) begin errors++; $display("FAIL zero_index got %0d exp 6", peak_index); end
    vectors++; if (peak_mag !== 44'd0) begin errors++; $display("FAIL zero_mag got %0d exp 0", peak_mag); end
    vectors++; if (peak_found !== 1'b0) begin errors++; $display("FAIL zero_found got %0d exp 0", peak_found); end
    vectors++; if (peak_frequency !== 32'd375000) begin errors++; $display("FAIL zero_freq got %0d exp 375000", peak_frequency); end
  endtask

  task automatic test_premature_sync(input bit gaps);
    clear_q();
    fc0 = frame_count;
    se0 = sync_err_count;
    fill(22'sd1, 22'sd1);
    fre[2] = 22'sd100;
    run_frame(4'd0, 4'd15, 44'd5000, gaps, 9);
    load_basic();
    fre[12] = 22'sd60;
    run_frame(4'd2, 4'd10, 44'd100, gaps, N);
    repeat (20) @(posedge clk_in);
    #1;
    vectors++; if (q_idx.size() != 1) begin errors++; $display("FAIL premature%0d_reports got %0d exp 1", gaps, q_idx.size()); end
    if (q_idx.size() >= 1) begin
      vectors++; if (q_idx[0] !== 4'd5) begin errors++; $display("FAIL premature%0d_index got %0d exp 5", gaps, q_idx[0]); end
      vectors++; if (q_mag[0] !== 44'd2500) begin errors++; $display("FAIL premature%0d_mag got %0d exp 2500", gaps, q_mag[0]); end
    end
    vectors++; if (peak_found !== 1'b1) begin errors++; $display("FAIL premature%0d_found got %0d exp 1", gaps, peak_found); end
    vectors++; if (sync_err_count !== se0 + 8'd1) begin errors++; $display("FAIL premature%0d_syncerr got %0d exp %0d", gaps, sync_err_count, se0 + 8'd1); end
    vectors++; if (frame_count !== fc0 + 16'd1) begin errors++; $display("FAIL premature%0d_frames got %0d exp %0d", gaps, frame_count, fc0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    fc0 = frame_count;
    load_basic();
    run_frame(4'd2, 4'd10, 44'd100, 1'b0, N);
    fill(22'sd1, 22'sd1);
    fre[9] = 22'sd60;
    fim[9] = 22'sd0;
    run_frame(4'd8, 4'd15, 44'd100, 1'b0, N);
    wait_reports(2);
    repeat (4) @(posedge clk_in);
    #1;
    vectors++; if (q_idx.size() != 2) begin errors++; $display("FAIL b2b_reports got %0d exp 2", q_idx.size()); end
    if (q_idx.size() >= 2) begin
      vectors++; if (q_idx[0] !== 4'd5) begin errors++; $display("FAIL b2b_first_index got %0d exp 5", q_idx[0]); end
      vectors++; if (q_mag[0] !== 44'd2500) begin errors++; $display("FAIL b2b_first_mag got %0d exp 2500", q_mag[0]); end
      vectors++; if (q_idx[1] !== 4'd9) begin errors++; $display("FAIL b2b_second_index got %0d exp 9", q_idx[1]); end
      vectors++; if (q_mag[1] !== 44'd3600) begin errors++; $display("FAIL b2b_second_mag got %0d exp 3600", q_mag[1]); end
      vectors++; if (q_freq[1] !== 32'd562500) begin errors++; $display("FAIL b2b_second_freq got %0d exp 562500", q_freq[1]); end
    end
    vectors++; if (frame_count !== fc0 + 16'd2) begin errors++; $display("FAIL b2b_frames got %0d exp %0d", frame_count, fc0 + 16'd2); end
  endtask

`ifdef SECOND_PEAK_EN
  task automatic test_second_peak();
    clear_q();
    fill(22'sd0, 22'sd0);
    fre[4] = 22'sd30;
    fre[6] = 22'sd50;
    fre[8] = 22'sd40;
    run_frame(4'd0, 4'd15, 44'd0, 1'b0, N);
    wait_reports(1);
    vectors++; if (peak_index !== 4'd6) begin errors++; $display("FAIL p2_main_index got %0d exp 6", peak_index); end
    vectors++; if (peak2_index !== 4'd8) begin errors++; $display("FAIL p2_index got %0d exp 8", peak2_index); end
    vectors++; if (peak2_mag !== 44'd1600) begin errors++; $display("FAIL p2_mag got %0d exp 1600", peak2_mag); end
  endtask
`endif

  task automatic test_reset_midframe();
    clear_q();
    load_basic();
    run_frame(4'd2, 4'd10, 44'd100, 1'b0, 10);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (20) @(posedge clk_in);
    #1;
    vectors++; if (q_idx.size() != 0) begin errors++; $display("FAIL rstmid_reports got %0d exp 0", q_idx.size()); end
    vectors++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rstmid_frames got %0d exp 0", frame_count); end
    vectors++; if (sync_err_count !== 8'd0) begin errors++; $display("FAIL rstmid_syncerr got %0d exp 0", sync_err_count); end
    vectors++; if (peak_index !== 4'd0) begin errors++; $display("FAIL rstmid_index got %0d exp 0", peak_index); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold_equal();
    test_overflow();
    test_empty_window();
    test_zero_window();
    test_premature_sync(1'b0);
    test_premature_sync(1'b1);
    test_back_to_back();
`ifdef SECOND_PEAK_EN
    test_second_peak();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fft_peak_tracker.md
Name: fft_peak_tracker

Overview:
Streaming spectral peak detector that consumes one FFT frame (bin-serial {real,imag} words plus a frame-start sync) and reports the strongest bin inside a runtime-programmable bin window. Successor to the fixed 2048-point, hard-coded-window peak finder. Adds parametrised size and width, a runtime window and threshold, overflow-safe pipelined magnitude, and sync-error recovery. Sits directly after the FFT core; feeds the range/velocity logic and debug display.

Parameters:
FFT_SIZE, 2048, points per frame; power of two, 16..65536
DATA_WIDTH, 22, signed width of each real/imag component
SAMPLE_RATE, 1000000, sample rate in Hz used for frequency conversion
IDX_W, $clog2(FFT_SIZE), bin index width (derived; do not override)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
s_valid  input  1  input bin word valid (FFT clock enable qualifier)
s_sync  input  1  high with bin 0 of a frame; ignored unless s_valid
s_data  input  2*DATA_WIDTH  {real[2DW-1:DW], imag[DW-1:0]}, two's complement
bin_lo  input  IDX_W  lowest bin searched (inclusive); latched at frame start
bin_hi  input  IDX_W  highest bin searched (inclusive); latched at frame start
threshold  input  2*DATA_WIDTH  minimum magnitude² for a detection; latched at frame start
peak_valid  output  1  one-cycle pulse: frame result ready
peak_found  output  1  peak_mag > threshold and window non-empty
peak_index  output  IDX_W  bin of maximum magnitude²
peak_mag  output  2*DATA_WIDTH  maximum magnitude² (unsigned)
peak_frequency  output  32  (peak_index*SAMPLE_RATE)>>IDX_W, Hz
frame_count  output  16  completed frames, wraps
sync_err_count  output  8  aborted frames, saturates at 255

Behaviour:
- Reset: all outputs 0; state IDLE; internal max and bin counter 0.
- States: IDLE -> ACCUM on s_valid&&s_sync (that word is bin 0; bin_lo, bin_hi and threshold are latched). ACCUM -> DRAIN after the accepted word with bin == FFT_SIZE-1. DRAIN -> REPORT once the pipeline empties. REPORT -> IDLE after one cycle; peak_valid pulses in this cycle.
- Words with s_valid=0 are ignored; the bin counter advances only on accepted words. Gaps are allowed.
- Magnitude pipeline:
  - Stage 1 registers re² and im².
  - Stage 2 registers the sum as 2*DATA_WIDTH unsigned. This width cannot overflow; the worst case (-2^(DW-1) in both components) gives exactly 2^(2DW-1).
  - Stage 3 is the compare/update. The bin index travels with the data through the pipeline.
- Latency: peak_valid is asserted exactly 4 clk_in cycles after the cycle that accepts bin FFT_SIZE-1.
- Qualification: a bin is a candidate iff bin_lo <= idx <= bin_hi.
  - Update the stored max on strict >, so ties keep the lowest index.
  - Stored max starts at 0 each frame, so an all-zero window gives peak_index = bin_lo and peak_mag = 0.
- Empty window (bin_lo > bin_hi): no candidates; peak_found = 0; peak_index = 0; peak_mag = 0.
- peak_found = (peak_mag > threshold) && window non-empty. A magnitude equal to the threshold is not a detection.
- peak_index, peak_mag, peak_found, peak_frequency and second-peak outputs update at peak_valid and hold until the next peak_valid.
- frame_count increments at peak_valid.
- peak_frequency uses a 64-bit intermediate product; the low bits are truncated.
- s_sync while in ACCUM (premature sync):
  - The current frame is aborted with no peak_valid, and sync_err_count increments (saturating).
  - The syncing word becomes bin 0 of a new frame, and the window and threshold are re-latched.
  - In-flight pipeline entries from the aborted frame are discarded.
- s_sync while in DRAIN or REPORT: the current frame completes normally, and the syncing word starts the next frame. The pipeline accepts the new frame back-to-back with no lost bins.
- s_valid without s_sync in IDLE: the word is dropped silently.
- rst_in mid-frame: the frame is discarded with no peak_valid, and all counters clear.

Optional Feature:
SECOND_PEAK_EN:
- When defined, the block adds outputs peak2_index (IDX_W) and peak2_mag (2*DATA_WIDTH), which hold the runner-up candidate bin.
- Update rule: on a new max, the old max moves to second. Otherwise, a value strictly greater than the second replaces it. Ties do not displace the incumbent.
- peak2_mag and peak2_index are 0 if the window has fewer than 2 bins. They update with peak_valid.
- When not defined, these ports and their registers do not exist, and the remaining behaviour is identical.

Test Plan:
- FFT_SIZE=16, window 2..10, threshold 100, bin 5={30,40} (mag 2500), others {1,1} -> peak_valid 4 cycles after bin 15; peak_index=5; peak_mag=2500; peak_found=1; peak_frequency=312500.
- Same frame with threshold 2500 -> peak_found=0 and peak_index=5.
- Bins 3 and 7 both {-2^21,-2^21} (DW=22) -> peak_index=3; peak_mag=2^43 exactly, with no wrap.
- Window 12..4 -> peak_found=0, peak_index=0, peak_mag=0; frame_count still increments.
- Sync reasserted at bin 9, then a full frame -> exactly one peak_valid, sync_err_count=1, and the result reflects the second frame only. Repeat with random s_valid gaps -> identical result.
- SECOND_PEAK_EN defined, mags 900@4, 2500@6, 1600@8 in window 0..15 -> peak2_index=8, peak2_mag=1600; back-to-back frames -> both reported, frame_count=2.
